linear_proj_seq: RTL and testbench
==================================

# linear_proj_seq

Tile sequencer for the multi-head linear projection stage. Walks A-matrix and B-weight memory addresses tile by tile across a runtime-selectable subset of up to `NUM_WEIGHT_SETS` projections (Q/K/V…) and drives read enables and accumulation markers to the multi-matmul array. Counts finished output tiles and reports each tile's row, column and weight-set coordinates. Sits between the input/weight BRAMs and `multi_matmul_wrapper`.

## Interface
- `A_OUTER_DIMENSION`, 16: rows of A.
- `B_OUTER_DIMENSION`, 16: columns of each weight matrix.
- `INNER_DIMENSION`, 6: shared inner dimension.
- `BLOCK_SIZE`, 2: systolic block edge.
- `NUM_CORES_A`, 2 / `NUM_CORES_B`, 1: cores per operand.
- `TOTAL_INPUT_W`, 2: parallel A ports.
- `TOTAL_MODULES`, 4: matmul modules in parallel.
- `NUM_WEIGHT_SETS`, 3: projections stored back to back in B memory.
- Derived: `ROW_T = A_OUTER_DIMENSION/(BLOCK_SIZE*NUM_CORES_A*TOTAL_INPUT_W)`, `COL_T = B_OUTER_DIMENSION/(BLOCK_SIZE*NUM_CORES_B*TOTAL_MODULES)`, `K_T = INNER_DIMENSION/BLOCK_SIZE`, `AW = max(1,$clog2(ROW_T*K_T))`, `BW = max(1,$clog2(NUM_WEIGHT_SETS*COL_T*K_T))`, `FW = $clog2(NUM_WEIGHT_SETS*ROW_T*COL_T+1)`.

- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle launch pulse; ignored unless IDLE.
- `wset_mask` in NUM_WEIGHT_SETS: projections to run; sampled on accepted `start`.
- `rd_ready` in 1: memories/matmul can accept a read this cycle.
- `tile_done_in` in 1: matmul finished current output tile.
- `rd_en` out 1: read issued this cycle.
- `a_addr` out AW: A memory word address.
- `b_addr` out BW: B memory word address.
- `first_k` / `last_k` out 1: first/last inner step of tile, valid with `rd_en`.
- `flag_valid` out 1: one-cycle pulse per completed tile.
- `flag_row` out $clog2(ROW_T)+1, `flag_col` out $clog2(COL_T)+1, `flag_wset` out $clog2(NUM_WEIGHT_SETS)+1: completed tile coordinates.
- `flag_cnt` out FW: tiles completed since `start`.
- `busy` out 1, `done` out 1 (one-cycle pulse), `err` out 1 (sticky).

## Operation
- States: IDLE, ISSUE, WAIT_TILE, DONE.
- IDLE: on `start`, latch mask, clear `flag_cnt`, `err`, counters r=c=k=0, w = lowest set mask bit → ISSUE. Mask 0 → DONE directly.
- ISSUE: `rd_en = rd_ready` (combinational from state). `a_addr = r*K_T + k`; `b_addr = w*COL_T*K_T + c*K_T + k`; `first_k = (k==0)`, `last_k = (k==K_T-1)`. k advances only when `rd_en`. `rd_en` with `last_k` → WAIT_TILE.
- WAIT_TILE: on `tile_done_in`, pulse `flag_valid` with current r/c/w, increment `flag_cnt`, k=0; advance c; on c wrap advance r; on r wrap advance w to next set mask bit; no bit left → DONE, else → ISSUE.
- DONE: `done`=1 one cycle → IDLE.
- `tile_done_in` outside WAIT_TILE: ignored, sets `err`.
- `start` while not IDLE: ignored, no effect on `err`.
- `busy`=1 in ISSUE and WAIT_TILE.

## Timing
- Reset: state IDLE; all outputs 0 (`rd_en`, `first_k`, `last_k`, addresses, flags, `flag_cnt`, `busy`, `done`, `err`).
- `start` cycle N → `busy` and first `rd_en` possible cycle N+1.
- Addresses registered; stall (`rd_ready`=0) holds addresses and markers stable.
- `flag_valid` in the cycle after `tile_done_in` is sampled; next tile's first `rd_en` the cycle after that.
- Unstalled, tile_done one cycle after last read: per tile K_T+2 cycles.
- `done` the cycle after last flag.
- `rst` mid-operation: IDLE next edge, no `done`, no flag.

## Structure
- Derived constants (ROW_T, COL_T, K_T, AW, BW, FW) and the state enum typedef go into the shared linear projection package.
- One sub-module: `linear_proj_wrap_cnt` (parametrised modulo counter with enable, clear, wrap output), instanced for k, c, r.
- Next-set-bit search for w is a function in the package.

## Test plan
- Defaults, mask 3'b111, `rd_ready`=1, `tile_done_in` 1 cycle after `last_k`: 12 tiles, 36 reads; tile (w0,r0,c0) a 0,1,2 b 0,1,2; (w0,r0,c1) a 0,1,2 b 3,4,5; (w0,r1,c0) a 3,4,5 b 0,1,2; w1 b base 6, w2 base 12; `flag_cnt`=12, one `done`.
- Mask 3'b101: w1 skipped; b_addr jumps 5→12 after w0; `flag_cnt`=8; `flag_wset` only 0 and 2.
- Mask 3'b000: `done` cycle N+1, no `rd_en`, `flag_cnt`=0.
- `rd_ready` toggling 1,0,0,1 mid-tile: addresses hold during 0s; exactly 3 reads per tile, `first_k`/`last_k` once each.
- `tile_done_in` asserted during ISSUE: ignored, `err`=1 until next accepted `start`.
- `rst` at read 5: next cycle all outputs 0, IDLE; new `start` restarts at a_addr 0, b_addr 0.

Source files
------------

// File: rtl/linear_proj_pkg.sv
// Shared constants, state encoding and weight-set search helper for the
// linear projection tile sequencer.
package linear_proj_pkg;

    localparam int A_OUTER_DIMENSION = 16;
    localparam int B_OUTER_DIMENSION = 16;
    localparam int INNER_DIMENSION   = 6;
    localparam int BLOCK_SIZE        = 2;
    localparam int NUM_CORES_A       = 2;
    localparam int NUM_CORES_B       = 1;
    localparam int TOTAL_INPUT_W     = 2;
    localparam int TOTAL_MODULES     = 4;
    localparam int NUM_WEIGHT_SETS   = 3;

    localparam int ROW_T = A_OUTER_DIMENSION / (BLOCK_SIZE * NUM_CORES_A * TOTAL_INPUT_W);
    localparam int COL_T = B_OUTER_DIMENSION / (BLOCK_SIZE * NUM_CORES_B * TOTAL_MODULES);
    localparam int K_T   = INNER_DIMENSION / BLOCK_SIZE;

    localparam int AW  = ($clog2(ROW_T * K_T) > 1) ? $clog2(ROW_T * K_T) : 1;
    localparam int BW  = ($clog2(NUM_WEIGHT_SETS * COL_T * K_T) > 1) ?
                         $clog2(NUM_WEIGHT_SETS * COL_T * K_T) : 1;
    localparam int FW  = $clog2(NUM_WEIGHT_SETS * ROW_T * COL_T + 1);
    localparam int RW  = $clog2(ROW_T) + 1;
    localparam int CW  = $clog2(COL_T) + 1;
    localparam int WSW = $clog2(NUM_WEIGHT_SETS) + 1;
    localparam int KW  = ($clog2(K_T) > 1) ? $clog2(K_T) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_TILE,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic           found;
        logic [WSW-1:0] idx;
    } wset_sel_t;

    // Lowest set mask bit at or above 'from'; found=0 when none remain.
    function automatic wset_sel_t next_wset(input logic [NUM_WEIGHT_SETS-1:0] mask,
                                            input int unsigned from);
        wset_sel_t res;
        res = '0;
        for (int i = NUM_WEIGHT_SETS - 1; i >= 0; i--) begin
            if (i >= int'(from) && mask[i]) begin
                res.found = 1'b1;
                res.idx   = WSW'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/linear_proj_wrap_cnt.sv
// Modulo counter with synchronous clear; wrap flags the enabled terminal step.
module linear_proj_wrap_cnt #(
    parameter int MODULUS = 2,
    parameter int WIDTH   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        wrap  = en && (cnt_q == WIDTH'(MODULUS - 1));
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = wrap ? '0 : cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/linear_proj_seq.sv
// Tile sequencer: walks A/B addresses over k, c, r for each enabled weight set
// and reports completed output tiles to the downstream matmul array.
module linear_proj_seq
    import linear_proj_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [NUM_WEIGHT_SETS-1:0] wset_mask,
    input  logic                       rd_ready,
    input  logic                       tile_done_in,
    output logic                       rd_en,
    output logic [AW-1:0]              a_addr,
    output logic [BW-1:0]              b_addr,
    output logic                       first_k,
    output logic                       last_k,
    output logic                       flag_valid,
    output logic [RW-1:0]              flag_row,
    output logic [CW-1:0]              flag_col,
    output logic [WSW-1:0]             flag_wset,
    output logic [FW-1:0]              flag_cnt,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    state_e                     state_q, state_d;
    logic [NUM_WEIGHT_SETS-1:0] mask_q, mask_d;
    logic [WSW-1:0]             w_q, w_d;
    logic                       last_tile_q, last_tile_d;
    logic                       flag_valid_q, flag_valid_d;
    logic [RW-1:0]              flag_row_q, flag_row_d;
    logic [CW-1:0]              flag_col_q, flag_col_d;
    logic [WSW-1:0]             flag_wset_q, flag_wset_d;
    logic [FW-1:0]              flag_cnt_q, flag_cnt_d;
    logic                       err_q, err_d;

    logic [KW-1:0] k_cnt;
    logic [CW-1:0] c_cnt;
    logic [RW-1:0] r_cnt;
    logic          k_wrap, c_wrap, r_wrap;
    logic          start_accept, tile_accept;
    wset_sel_t     first_sel, next_sel;

    assign start_accept = (state_q == ST_IDLE) && start;
    // A second tile_done during the flag cycle must not retire another tile.
    assign tile_accept  = (state_q == ST_WAIT_TILE) && tile_done_in && !flag_valid_q;
    assign first_sel    = next_wset(wset_mask, 32'd0);
    assign next_sel     = next_wset(mask_q, 32'(w_q) + 32'd1);

    linear_proj_wrap_cnt #(.MODULUS(K_T), .WIDTH(KW)) u_k_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_accept),
        .en   (rd_en),
        .cnt  (k_cnt),
        .wrap (k_wrap)
    );

    linear_proj_wrap_cnt #(.MODULUS(COL_T), .WIDTH(CW)) u_c_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_accept),
        .en   (tile_accept),
        .cnt  (c_cnt),
        .wrap (c_wrap)
    );

    linear_proj_wrap_cnt #(.MODULUS(ROW_T), .WIDTH(RW)) u_r_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_accept),
        .en   (c_wrap),
        .cnt  (r_cnt),
        .wrap (r_wrap)
    );

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        w_d          = w_q;
        last_tile_d  = last_tile_q;
        flag_valid_d = 1'b0;
        flag_row_d   = flag_row_q;
        flag_col_d   = flag_col_q;
        flag_wset_d  = flag_wset_q;
        flag_cnt_d   = flag_cnt_q;
        err_d        = err_q;

        if (tile_done_in && state_q != ST_WAIT_TILE) begin
            err_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mask_d      = wset_mask;
                    flag_cnt_d  = '0;
                    err_d       = tile_done_in;
                    last_tile_d = 1'b0;
                    w_d         = first_sel.found ? first_sel.idx : '0;
                    state_d     = first_sel.found ? ST_ISSUE : ST_DONE;
                end
            end
            ST_ISSUE: begin
                if (k_wrap) begin
                    state_d = ST_WAIT_TILE;
                end
            end
            ST_WAIT_TILE: begin
                // The flag cycle is spent in WAIT_TILE so each tile costs K_T+2 cycles.
                if (flag_valid_q) begin
                    state_d = last_tile_q ? ST_DONE : ST_ISSUE;
                end else if (tile_accept) begin
                    flag_valid_d = 1'b1;
                    flag_row_d   = r_cnt;
                    flag_col_d   = c_cnt;
                    flag_wset_d  = w_q;
                    flag_cnt_d   = flag_cnt_q + FW'(1);
                    if (r_wrap) begin
                        if (next_sel.found) begin
                            w_d = next_sel.idx;
                        end else begin
                            last_tile_d = 1'b1;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            mask_q       <= '0;
            w_q          <= '0;
            last_tile_q  <= 1'b0;
            flag_valid_q <= 1'b0;
            flag_row_q   <= '0;
            flag_col_q   <= '0;
            flag_wset_q  <= '0;
            flag_cnt_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            w_q          <= w_d;
            last_tile_q  <= last_tile_d;
            flag_valid_q <= flag_valid_d;
            flag_row_q   <= flag_row_d;
            flag_col_q   <= flag_col_d;
            flag_wset_q  <= flag_wset_d;
            flag_cnt_q   <= flag_cnt_d;
            err_q        <= err_d;
        end
    end

    assign rd_en   = (state_q == ST_ISSUE) && rd_ready;
    assign first_k = (state_q == ST_ISSUE) && (k_cnt == '0);
    assign last_k  = (state_q == ST_ISSUE) && (k_cnt == KW'(K_T - 1));
    assign a_addr  = AW'(r_cnt) * AW'(K_T) + AW'(k_cnt);
    assign b_addr  = BW'(w_q) * BW'(COL_T * K_T) + BW'(c_cnt) * BW'(K_T) + BW'(k_cnt);

    assign flag_valid = flag_valid_q;
    assign flag_row   = flag_row_q;
    assign flag_col   = flag_col_q;
    assign flag_wset  = flag_wset_q;
    assign flag_cnt   = flag_cnt_q;
    assign busy       = (state_q == ST_ISSUE) || (state_q == ST_WAIT_TILE);
    assign done       = (state_q == ST_DONE);
    assign err        = err_q;

endmodule

// File: tb/tb_linear_proj_seq.sv
// Self-checking bench for linear_proj_seq: a loop-nest model of the tile walk
// is compared against the read stream, tile flags and completion pulse.
module tb_linear_proj_seq;
    import linear_proj_pkg::*;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       start = 1'b0;
    logic [NUM_WEIGHT_SETS-1:0] wset_mask = '0;
    logic                       rd_ready = 1'b0;
    logic                       tile_done_in = 1'b0;
    logic                       rd_en, first_k, last_k, flag_valid, busy, done, err;
    logic [AW-1:0]              a_addr;
    logic [BW-1:0]              b_addr;
    logic [RW-1:0]              flag_row;
    logic [CW-1:0]              flag_col;
    logic [WSW-1:0]             flag_wset;
    logic [FW-1:0]              flag_cnt;

    linear_proj_seq dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .wset_mask    (wset_mask),
        .rd_ready     (rd_ready),
        .tile_done_in (tile_done_in),
        .rd_en        (rd_en),
        .a_addr       (a_addr),
        .b_addr       (b_addr),
        .first_k      (first_k),
        .last_k       (last_k),
        .flag_valid   (flag_valid),
        .flag_row     (flag_row),
        .flag_col     (flag_col),
        .flag_wset    (flag_wset),
        .flag_cnt     (flag_cnt),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    typedef struct {
        int a;
        int b;
        bit first;
        bit last;
    } read_t;

    typedef struct {
        int row;
        int col;
        int wset;
        int cnt;
    } flag_t;

    read_t exp_reads[$];
    flag_t exp_flags[$];
    read_t cur_read;
    flag_t cur_flag;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit check_en = 1'b0;
    bit resp_en = 1'b1;
    bit fixed_delay = 1'b1;
    bit run_has_tiles = 1'b0;
    int ready_mode = 0;
    int resp_delay = 1;
    int reads_seen = 0;
    int done_count = 0;
    int tiles_in_run = 0;
    int last_flag_cyc = 0;
    int last_first_cyc = 0;

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Expected read stream and tile flags straight from the loop nest w, r, c, k.
    task automatic build_model(input logic [NUM_WEIGHT_SETS-1:0] mask);
        int n;
        n = 0;
        exp_reads.delete();
        exp_flags.delete();
        for (int w = 0; w < NUM_WEIGHT_SETS; w++) begin
            if (mask[w]) begin
                for (int r = 0; r < ROW_T; r++) begin
                    for (int c = 0; c < COL_T; c++) begin
                        n++;
                        exp_flags.push_back('{r, c, w, n});
                        for (int k = 0; k < K_T; k++) begin
                            exp_reads.push_back('{r * K_T + k, (w * COL_T + c) * K_T + k,
                                                  k == 0, k == K_T - 1});
                        end
                    end
                end
            end
        end
    endtask

    task automatic checkIdleZero(input string tag);
        checkOutput({tag, "_rd_en"}, rd_en, 0);
        checkOutput({tag, "_first_k"}, first_k, 0);
        checkOutput({tag, "_last_k"}, last_k, 0);
        checkOutput({tag, "_a_addr"}, a_addr, 0);
        checkOutput({tag, "_b_addr"}, b_addr, 0);
        checkOutput({tag, "_flag_valid"}, flag_valid, 0);
        checkOutput({tag, "_flag_row"}, flag_row, 0);
        checkOutput({tag, "_flag_col"}, flag_col, 0);
        checkOutput({tag, "_flag_wset"}, flag_wset, 0);
        checkOutput({tag, "_flag_cnt"}, flag_cnt, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_err"}, err, 0);
    endtask

    // Compare process: every output event is checked against the model queues.
    initial forever begin
        @(negedge clk);
        if (check_en) begin
            if (rd_en) begin
                reads_seen++;
                checkOutput("rd_en_without_ready", rd_ready, 1);
                if (exp_reads.size() == 0) begin
                    checkOutput("extra_read", 1, 0);
                end else begin
                    cur_read = exp_reads.pop_front();
                    checkOutput("a_addr", a_addr, cur_read.a);
                    checkOutput("b_addr", b_addr, cur_read.b);
                    checkOutput("first_k", first_k, cur_read.first);
                    checkOutput("last_k", last_k, cur_read.last);
                    if (first_k) begin
                        if (fixed_delay && ready_mode == 0 && tiles_in_run > 0)
                            checkOutput("tile_period", cyc - last_first_cyc, K_T + 2);
                        last_first_cyc = cyc;
                        tiles_in_run++;
                    end
                end
            end else if (first_k || last_k) begin
                checkOutput("stall_without_ready", rd_ready, 0);
                if (exp_reads.size() > 0) begin
                    checkOutput("stall_a_addr", a_addr, exp_reads[0].a);
                    checkOutput("stall_b_addr", b_addr, exp_reads[0].b);
                    checkOutput("stall_first_k", first_k, exp_reads[0].first);
                    checkOutput("stall_last_k", last_k, exp_reads[0].last);
                end
            end
            if (flag_valid) begin
                if (exp_flags.size() == 0) begin
                    checkOutput("extra_flag", 1, 0);
                end else begin
                    cur_flag = exp_flags.pop_front();
                    checkOutput("flag_row", flag_row, cur_flag.row);
                    checkOutput("flag_col", flag_col, cur_flag.col);
                    checkOutput("flag_wset", flag_wset, cur_flag.wset);
                    checkOutput("flag_cnt", flag_cnt, cur_flag.cnt);
                end
                last_flag_cyc = cyc;
            end
            if (done) begin
                done_count++;
                if (run_has_tiles) checkOutput("done_after_last_flag", cyc - last_flag_cyc, 1);
                checkOutput("done_reads_left", exp_reads.size(), 0);
                checkOutput("done_flags_left", exp_flags.size(), 0);
            end
        end
    end

    // Matmul stand-in: raises tile_done_in a short time after each last_k read.
    initial forever begin
        @(negedge clk);
        if (resp_en && check_en && rd_en && last_k) begin
            resp_delay = fixed_delay ? 1 : int'($urandom_range(1, 3));
            repeat (resp_delay) @(posedge clk);
            #1 tile_done_in = 1'b1;
            @(posedge clk);
            #1 tile_done_in = 1'b0;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       rd_ready = 1'b1;
            1:       rd_ready = ($urandom_range(0, 3) != 0);
            default: rd_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        endcase
    end

    task automatic applyStimulus(input logic [NUM_WEIGHT_SETS-1:0] mask, input int mode,
                                 input bit inject_err, input bit inject_start);
        ready_mode    = mode;
        fixed_delay   = (mode == 0);
        build_model(mask);
        run_has_tiles = (mask != 0);
        done_count    = 0;
        tiles_in_run  = 0;
        check_en      = 1'b1;
        @(posedge clk);
        #1 wset_mask = mask;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        if (inject_err) tile_done_in = 1'b1;
        @(negedge clk);
        checkOutput("busy_after_start", busy, mask != 0);
        checkOutput("err_cleared_on_start", err, 0);
        if (mask == 0) checkOutput("done_empty_mask", done, 1);
        if (mask != 0 && mode == 0) checkOutput("first_read_next_cycle", rd_en, 1);
        @(posedge clk);
        #1;
        if (inject_err) tile_done_in = 1'b0;
        if (inject_start) begin
            repeat (4) @(posedge clk);
            #1 start = 1'b1;
            wset_mask = ~mask;
            @(posedge clk);
            #1 start = 1'b0;
            wset_mask = mask;
        end
        for (int t = 0; t < 3000 && done_count == 0; t++) @(negedge clk);
        if (done_count == 0) checkOutput("timeout_waiting_done", 0, 1);
        repeat (3) @(negedge clk);
        checkOutput("done_pulses", done_count, 1);
        checkOutput("reads_left", exp_reads.size(), 0);
        checkOutput("flags_left", exp_flags.size(), 0);
        checkOutput("flag_cnt_final", flag_cnt, $countones(mask) * ROW_T * COL_T);
        checkOutput("err_final", err, inject_err);
        checkOutput("busy_final", busy, 0);
    endtask

    task automatic resetMidRun();
        ready_mode    = 0;
        fixed_delay   = 1'b1;
        build_model(3'b111);
        run_has_tiles = 1'b1;
        done_count    = 0;
        tiles_in_run  = 0;
        reads_seen    = 0;
        check_en      = 1'b1;
        @(posedge clk);
        #1 wset_mask = 3'b111;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            #1;
            if (reads_seen >= 5) break;
        end
        checkOutput("reads_before_reset", reads_seen, 5);
        check_en = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkIdleZero("mid_reset");
        @(negedge clk);
        checkOutput("mid_reset_no_done", done, 0);
        checkOutput("mid_reset_no_flag", flag_valid, 0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkIdleZero("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        build_model(3'b111);
        checkOutput("model_reads_111", exp_reads.size(), 36);
        checkOutput("model_flags_111", exp_flags.size(), 12);
        checkOutput("model_t1_b", exp_reads[3].b, 3);
        checkOutput("model_t2_a", exp_reads[6].a, 3);
        checkOutput("model_t2_b", exp_reads[6].b, 0);
        checkOutput("model_w1_base", exp_reads[12].b, 6);
        checkOutput("model_w2_base", exp_reads[24].b, 12);
        build_model(3'b101);
        checkOutput("model_reads_101", exp_reads.size(), 24);
        checkOutput("model_101_w0_end", exp_reads[11].b, 5);
        checkOutput("model_101_w2_start", exp_reads[12].b, 12);
        checkOutput("model_101_wset", exp_flags[4].wset, 2);

        applyStimulus(3'b111, 0, 1'b0, 1'b0);
        applyStimulus(3'b101, 0, 1'b0, 1'b0);
        applyStimulus(3'b000, 0, 1'b0, 1'b0);
        applyStimulus(3'b111, 2, 1'b0, 1'b0);
        applyStimulus(3'b001, 0, 1'b1, 1'b0);
        applyStimulus(3'b111, 0, 1'b0, 1'b1);
        resetMidRun();
        applyStimulus(3'b111, 0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(NUM_WEIGHT_SETS'($urandom_range(0, (1 << NUM_WEIGHT_SETS) - 1)),
                          1, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
